uart_prog_loader: RTL and testbench
===================================

Name: uart_prog_loader

Overview:
- On-chip receiving end of the UART program-load link: deserialises 8N1 bytes arriving on the user-project RX pin (mprj_io[5]).
- Packs every 4 bytes into a 32-bit little-endian word and writes it into the FPU core's instruction memory.
- Signals load completion on a ready output, which drives mprj_io[37]. The core is held off until that output is high.

Parameters:
- CLKS_PER_BIT, 347, clock cycles per UART bit (40 MHz / 115200); legal minimum 4.
- ADDR_WIDTH, 8, instruction memory word-address width.
- STOP_WORD, 32'h0000_0FFF, end-of-program marker word; never written to memory.

Ports:
- wb_clk_i  input  1  system clock
- wb_rst_i  input  1  synchronous, active-high reset
- rx_i  input  1  UART serial in, idle high, asynchronous to wb_clk_i
- imem_we_o  output  1  one-cycle instruction-memory write strobe
- imem_addr_o  output  ADDR_WIDTH  word address for the write
- imem_wdata_o  output  32  write data
- prog_done_o  output  1  sticky; load complete, drives mprj_ready
- frame_err_o  output  1  sticky; at least one bad stop bit seen
- busy_o  output  1  receiver is inside a frame (not IDLE)

Behaviour:
- Reset (wb_rst_i high at a clock edge):
  - all outputs 0; FSM to IDLE; byte count, word address, bit counter, baud counter and shift register cleared.
  - Reset mid-frame or mid-word discards the partial byte and word.
- Input sync: rx_i passes through a 2-FF synchroniser; rx_s is the 2nd-stage output. All sampling uses rx_s.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: when rx_s = 0, go to START and clear the baud counter.
  - START: at count CLKS_PER_BIT/2-1 (mid start bit), re-sample rx_s.
    - rx_s = 0: go to DATA and restart the counter.
    - rx_s = 1: glitch; return to IDLE with no byte.
  - DATA: sample rx_s every CLKS_PER_BIT cycles, i.e. at bit centres. LSB first, 8 bits, then go to STOP.
  - STOP: sample at the stop-bit centre, then return to IDLE.
    - rx_s = 1: raise internal byte_valid for 1 cycle.
    - rx_s = 0: set frame_err_o; discard the byte; byte count unchanged.
  - busy_o = 1 in every state except IDLE.
- Word assembly: byte k (k = 0..3) goes to word[8k+7:8k]. On the 4th valid byte the word is complete and the byte count resets to 0.
- Completed word = STOP_WORD: prog_done_o = 1 on the next cycle; no write.
- Any other completed word, on the cycle after byte_valid:
  - imem_we_o = 1 for exactly 1 cycle; imem_addr_o = current address; imem_wdata_o = the word.
  - Address then increments.
  - imem_addr_o and imem_wdata_o hold their values until the next write.
- Memory full: a write to address 2^ADDR_WIDTH-1 also sets prog_done_o on that cycle. The address does not wrap.
- After prog_done_o = 1:
  - the receiver keeps running and frame_err_o still updates;
  - completed words are ignored and no further writes occur, until reset.
- A frame arriving back-to-back (start edge on the cycle after STOP) must be captured. The write strobe never overlaps the capture of the next byte's start edge.
- Latency: imem_we_o rises exactly 1 cycle after the stop-bit-centre sample of the 4th byte. The total from the 4th byte's start edge is about 9.5×CLKS_PER_BIT + 4 cycles.

Test Plan (CLKS_PER_BIT = 8 unless noted):
- Send bytes 78 56 34 12 -> one imem_we_o pulse, addr 0, wdata 0x12345678. Then DE AD BE EF -> addr 1, wdata 0xEFBEADDE. prog_done_o stays 0.
- After the two words above, send FF 0F 00 00 -> no write; prog_done_o = 1 and stays 1. A further 4 bytes 11 22 33 44 -> no write.
- Frame 0x55 with the stop bit driven 0 -> frame_err_o = 1, no byte counted. The next 4 good bytes 01 00 00 00 -> write addr 0, wdata 0x00000001.
- rx_i low pulse of 2 cycles, then idle -> FSM back to IDLE, no byte, busy_o low by the mid-start sample plus 1 cycle, no error.
- ADDR_WIDTH = 2, send 4 words -> writes at addr 0..3. prog_done_o rises on the cycle of the addr-3 write. A 5th word -> no write.
- Assert wb_rst_i during the 3rd data bit of the 2nd byte of a word -> all outputs 0. A fresh word AA BB CC DD -> write addr 0, wdata 0xDDCCBBAA.

Source files
------------

// File: rtl/uart_prog_loader.sv
// UART 8N1 program loader: receives bytes, packs them little-endian into 32-bit words
// and writes each word to instruction memory until the stop word or memory end.
module uart_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 347,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter logic [31:0] STOP_WORD    = 32'h0000_0FFF
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  rx_i,
  output logic                  imem_we_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [31:0]           imem_wdata_o,
  output logic                  prog_done_o,
  output logic                  frame_err_o,
  output logic                  busy_o
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrLast = '1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic                  rx_meta_q, rx_s_q;
  state_e                state_q, state_d;
  logic [CntW-1:0]       baud_q, baud_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  ferr_q, ferr_d;
  logic                  byte_valid;
  logic [31:0]           full_word;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    ferr_d     = ferr_q;
    byte_valid = 1'b0;
    full_word  = {shift_q, word_q};

    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          baud_d  = '0;
        end
      end
      StStart: begin
        if (baud_q == HalfLast) begin
          baud_d    = '0;
          bit_cnt_d = '0;
          // A high level at mid start bit means the falling edge was a glitch
          state_d   = rx_s_q ? StIdle : StData;
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      StData: begin
        if (baud_q == BitLast) begin
          baud_d    = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      StStop: begin
        if (baud_q == BitLast) begin
          baud_d  = '0;
          state_d = StIdle;
          if (rx_s_q) begin
            byte_valid = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (byte_valid) begin
      if (byte_cnt_q != 2'd3) begin
        word_d[{byte_cnt_q, 3'b000} +: 8] = shift_q;
        byte_cnt_d = byte_cnt_q + 2'd1;
      end else begin
        byte_cnt_d = '0;
        // Once done, completed words are dropped until reset
        if (!done_q) begin
          if (full_word == STOP_WORD) begin
            done_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = full_word;
            if (addr_q == AddrLast) begin
              done_d = 1'b1;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      // Synchroniser resets to the idle line level so no false start follows reset
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= rx_i;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = waddr_q;
  assign imem_wdata_o = wdata_q;
  assign prog_done_o  = done_q;
  assign frame_err_o  = ferr_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: two instances (8-bit and 2-bit address) driven with
// directed and random UART traffic, checked against a byte-level reference model.
module tb_uart_prog_loader;

  localparam int unsigned C    = 8;
  localparam logic [31:0] STOP = 32'h0000_0FFF;
  localparam int unsigned LatLo = C * 19 / 2;
  localparam int unsigned LatHi = LatLo + 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [2];
  logic rx  [2];

  logic        we0, done0, ferr0, busy0;
  logic [7:0]  addr0;
  logic [31:0] wd0;
  logic        we1, done1, ferr1, busy1;
  logic [1:0]  addr1;
  logic [31:0] wd1;

  uart_prog_loader #(.CLKS_PER_BIT(C), .ADDR_WIDTH(8), .STOP_WORD(STOP)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst[0]), .rx_i(rx[0]), .imem_we_o(we0), .imem_addr_o(addr0),
    .imem_wdata_o(wd0), .prog_done_o(done0), .frame_err_o(ferr0), .busy_o(busy0)
  );

  uart_prog_loader #(.CLKS_PER_BIT(C), .ADDR_WIDTH(2), .STOP_WORD(STOP)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst[1]), .rx_i(rx[1]), .imem_we_o(we1), .imem_addr_o(addr1),
    .imem_wdata_o(wd1), .prog_done_o(done1), .frame_err_o(ferr1), .busy_o(busy1)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    int unsigned w;
    logic [31:0] addr;
    logic [31:0] data;
    logic        done;
  } wr_t;

  wr_t exp_q[$];
  wr_t act_q[$];

  // Reference model: list of good bytes per instance, word address, sticky flags
  logic [7:0]  m_bytes [2][4];
  int unsigned m_cnt   [2];
  logic [31:0] m_addr  [2];
  logic        m_done  [2];
  logic        m_ferr  [2];
  logic [31:0] m_max   [2];

  task automatic model_reset(input int w);
    m_cnt[w]  = 0;
    m_addr[w] = 0;
    m_done[w] = 1'b0;
    m_ferr[w] = 1'b0;
  endtask

  task automatic model_byte(input int w, input logic [7:0] b, input logic ok);
    logic [31:0] word;
    wr_t e;
    if (!ok) begin
      m_ferr[w] = 1'b1;
      return;
    end
    m_bytes[w][m_cnt[w]] = b;
    m_cnt[w]++;
    if (m_cnt[w] == 4) begin
      m_cnt[w] = 0;
      word = m_bytes[w][0] + (m_bytes[w][1] << 8) + (m_bytes[w][2] << 16)
           + (m_bytes[w][3] << 24);
      if (!m_done[w]) begin
        if (word == STOP) begin
          m_done[w] = 1'b1;
        end else begin
          e.w = w; e.addr = m_addr[w]; e.data = word; e.done = (m_addr[w] == m_max[w]);
          exp_q.push_back(e);
          if (m_addr[w] == m_max[w]) m_done[w] = 1'b1;
          else m_addr[w]++;
        end
      end
    end
  endtask

  logic        we_prev    [2];
  int unsigned last_start [2];

  task automatic mon(input int w, input logic we, input logic [31:0] addr,
                     input logic [31:0] data, input logic done);
    wr_t e;
    int unsigned lat;
    if (we_prev[w]) check("we_one_cycle", {31'b0, we}, 32'd0);
    if (we && !we_prev[w]) begin
      e.w = w; e.addr = addr; e.data = data; e.done = done;
      act_q.push_back(e);
      lat = cyc - last_start[w];
      check("write_latency_in_range", {31'b0, (lat >= LatLo && lat <= LatHi)}, 32'd1);
    end
    we_prev[w] = we;
  endtask

  always @(negedge clk) begin
    mon(0, we0, {24'b0, addr0}, wd0, done0);
    mon(1, we1, {30'b0, addr1}, wd1, done1);
  end

  task automatic compare_writes();
    wr_t a, e;
    check("write_count", act_q.size(), exp_q.size());
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      check("write_dut", a.w, e.w);
      check("write_addr", a.addr, e.addr);
      check("write_data", a.data, e.data);
      check("write_done_flag", {31'b0, a.done}, {31'b0, e.done});
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int w, input logic [7:0] b, input logic ok);
    last_start[w] = cyc;
    rx[w] = 1'b0;
    repeat (C) tick();
    for (int i = 0; i < 8; i++) begin
      rx[w] = b[i];
      repeat (C) tick();
    end
    rx[w] = ok;
    repeat (C) tick();
    rx[w] = 1'b1;
    model_byte(w, b, ok);
  endtask

  // Random 0..2 idle cycles between frames, so back-to-back frames occur
  task automatic send_word(input int w, input logic [31:0] word);
    for (int k = 0; k < 4; k++) begin
      send_frame(w, word[8*k +: 8], 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] v;
    v = $urandom;
    if (v == STOP) v = v ^ 32'h1;
    return v;
  endfunction

  task automatic do_reset(input int w);
    rst[w] = 1'b1;
    rx[w]  = 1'b1;
    repeat (2) tick();
    rst[w] = 1'b0;
    model_reset(w);
  endtask

  task automatic check_zero(input int w);
    if (w == 0) begin
      check("rst_we", {31'b0, we0}, 0);
      check("rst_addr", {24'b0, addr0}, 0);
      check("rst_wdata", wd0, 0);
      check("rst_done", {31'b0, done0}, 0);
      check("rst_ferr", {31'b0, ferr0}, 0);
      check("rst_busy", {31'b0, busy0}, 0);
    end else begin
      check("rst1_we", {31'b0, we1}, 0);
      check("rst1_addr", {30'b0, addr1}, 0);
      check("rst1_wdata", wd1, 0);
      check("rst1_done", {31'b0, done1}, 0);
      check("rst1_ferr", {31'b0, ferr1}, 0);
      check("rst1_busy", {31'b0, busy1}, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst[0] = 1'b1; rst[1] = 1'b1;
    rx[0]  = 1'b1; rx[1]  = 1'b1;
    we_prev[0] = 1'b0; we_prev[1] = 1'b0;
    last_start[0] = 0; last_start[1] = 0;
    m_max[0] = 255; m_max[1] = 3;
    repeat (3) tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    model_reset(0); model_reset(1);
    check_zero(0);
    check_zero(1);

    // Two directed words
    send_word(0, 32'h1234_5678);
    send_word(0, 32'hEFBE_ADDE);
    repeat (4) tick();
    compare_writes();
    check("done_after_two_words", {31'b0, done0}, 0);
    check("addr_holds", {24'b0, addr0}, 1);
    check("wdata_holds", wd0, 32'hEFBE_ADDE);

    // Random words with random inter-frame gaps
    repeat (4) send_word(0, rand_word());
    repeat (4) tick();
    compare_writes();

    // Stop word then trailing data
    send_word(0, STOP);
    repeat (4) tick();
    compare_writes();
    check("done_after_stop", {31'b0, done0}, 1);
    send_word(0, 32'h4433_2211);
    repeat (4) tick();
    compare_writes();
    check("done_sticky", {31'b0, done0}, 1);
    check("no_ferr_clean", {31'b0, ferr0}, 0);

    // Bad stop bit
    do_reset(0);
    check_zero(0);
    send_frame(0, 8'h55, 1'b0);
    repeat (C) tick();
    check("ferr_set", {31'b0, ferr0}, {31'b0, m_ferr[0]});
    send_word(0, 32'h0000_0001);
    repeat (4) tick();
    compare_writes();
    check("ferr_sticky", {31'b0, ferr0}, 1);

    // Two-cycle low glitch on rx
    do_reset(0);
    rx[0] = 1'b0;
    repeat (2) tick();
    rx[0] = 1'b1;
    repeat (2) tick();
    check("glitch_busy_high", {31'b0, busy0}, 1);
    repeat (4) tick();
    check("glitch_busy_low", {31'b0, busy0}, 0);
    repeat (2 * C) tick();
    check("glitch_no_ferr", {31'b0, ferr0}, 0);
    compare_writes();

    // Reset inside the third data bit of the second byte
    do_reset(0);
    send_frame(0, 8'h99, 1'b1);
    rx[0] = 1'b0;
    repeat (C) tick();
    rx[0] = 1'b1;
    repeat (C) tick();
    rx[0] = 1'b0;
    repeat (C) tick();
    rx[0] = 1'b1;
    repeat (C / 2) tick();
    check("midframe_busy", {31'b0, busy0}, 1);
    do_reset(0);
    check_zero(0);
    repeat (2 * C) tick();
    check("midframe_idle", {31'b0, busy0}, 0);
    send_word(0, 32'hDDCC_BBAA);
    repeat (4) tick();
    compare_writes();

    // Small memory: fills at address 3, fifth word dropped
    repeat (5) send_word(1, rand_word());
    repeat (4) tick();
    compare_writes();
    check("full_done", {31'b0, done1}, 1);
    check("full_addr_last", {30'b0, addr1}, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
